// File: rtl/display_bcd_converter.sv
// Latches the metric picked by mode_flags and converts it to packed BCD with a
// sequential double-dabble engine. Optional macro: LEADING_ZERO_BLANK_EN.
module display_bcd_converter #(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_bcd,
    input  logic [1:0]            mode_flags,
    input  logic [WIDTH-1:0]      day_dist,
    input  logic [WIDTH-1:0]      avg_speed,
    input  logic [WIDTH-1:0]      trip_time,
    input  logic [WIDTH-1:0]      max_speed,
    output logic [4*DIGITS-1:0]   bcd_digits,
    output logic [1:0]            disp_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int unsigned FULL_SCALE = pow10(DIGITS) - 1;
    localparam int unsigned WORK_W     = 4 * (DIGITS + 1);
    localparam int unsigned OUT_W      = 4 * DIGITS;
    localparam int unsigned CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    val_q;
    logic [WORK_W-1:0]   work_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          mode_q;
    logic                ovf_q;
    logic                pending_q;

    logic [WIDTH-1:0]    sel_c;
    logic [WORK_W-1:0]   adj_c;
    logic [WORK_W-1:0]   work_d;
    logic [OUT_W-1:0]    result_d;

    // Metric selection, add-3 correction, and the display word built at DONE
    always_comb begin
        sel_c = day_dist;
        case (mode_flags)
            2'b00:   sel_c = day_dist;
            2'b01:   sel_c = avg_speed;
            2'b10:   sel_c = trip_time;
            default: sel_c = max_speed;
        endcase

        adj_c = work_q;
        for (int i = 0; i <= int'(DIGITS); i++) begin
            if (work_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end
        work_d = WORK_W'({adj_c, val_q[WIDTH-1]});

        if (ovf_q) begin
            result_d = {DIGITS{4'h9}};
        end else begin
            result_d = work_q[OUT_W-1:0];
`ifdef LEADING_ZERO_BLANK_EN
            // Blank zeros from the top down; the least-significant digit always shows
            for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                if (result_d[OUT_W-1 -: 4] == 4'h0 || result_d[OUT_W-1 -: 4] == 4'hF) begin
                    if (result_d[4*i +: 4] == 4'h0 && (i == int'(DIGITS) - 1 || result_d[4*(i+1) +: 4] == 4'hF))
                        result_d[4*i +: 4] = 4'hF;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            val_q      <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            mode_q     <= 2'b00;
            ovf_q      <= 1'b0;
            pending_q  <= 1'b0;
            bcd_digits <= '0;
            disp_mode  <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_bcd || pending_q) begin
                        val_q     <= sel_c;
                        mode_q    <= mode_flags;
                        ovf_q     <= 32'(sel_c) > FULL_SCALE;
                        work_q    <= '0;
                        cnt_q     <= '0;
                        pending_q <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (start_bcd) pending_q <= 1'b1;
                    work_q <= work_d;
                    val_q  <= val_q << 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= DONE;
                end
                DONE: begin
                    if (start_bcd) pending_q <= 1'b1;
                    bcd_digits <= result_d;
                    overflow   <= ovf_q;
                    disp_mode  <= mode_q;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_bcd_converter.sv
// Scoreboard bench for display_bcd_converter: expected displays queued at request
// time, popped and compared on every done pulse.
module tb_display_bcd_converter;

    localparam int unsigned WIDTH  = 14;
    localparam int unsigned DIGITS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_bcd;
    logic [1:0]        mode_flags;
    logic [WIDTH-1:0]  day_dist, avg_speed, trip_time, max_speed;
    logic [15:0]       bcd_digits;
    logic [1:0]        disp_mode;
    logic              busy, done, overflow;

    typedef struct {
        logic [15:0] bcd;
        logic [1:0]  mode;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;

    display_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_bcd  (start_bcd),
        .mode_flags (mode_flags),
        .day_dist   (day_dist),
        .avg_speed  (avg_speed),
        .trip_time  (trip_time),
        .max_speed  (max_speed),
        .bcd_digits (bcd_digits),
        .disp_mode  (disp_mode),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Decimal model: digits by repeated division, then optional blanking
    function automatic exp_t model(input int unsigned v, input logic [1:0] m);
        exp_t        e;
        int unsigned x;
        logic        lead;
        e.mode = m;
        e.ovf  = (v > 9999);
        e.bcd  = 16'h9999;
        lead   = 1'b1;
        if (!e.ovf) begin
            x = v;
            for (int i = 0; i < 4; i++) begin
                e.bcd[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
`ifdef LEADING_ZERO_BLANK_EN
            for (int i = 3; i >= 1; i--) begin
                if (lead && e.bcd[4*i +: 4] == 4'h0) e.bcd[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
`endif
        end
        return e;
    endfunction

    task automatic set_metric(input logic [1:0] m, input int unsigned v);
        mode_flags = m;
        case (m)
            2'b00:   day_dist  = WIDTH'(v);
            2'b01:   avg_speed = WIDTH'(v);
            2'b10:   trip_time = WIDTH'(v);
            default: max_speed = WIDTH'(v);
        endcase
    endtask

    // Single isolated conversion with busy-length and done-pulse checks
    task automatic run_one(input logic [1:0] m, input int unsigned v);
        int n;
        @(negedge clk);
        set_metric(m, v);
        start_bcd = 1'b1;
        sb.push_back(model(v, m));
        @(negedge clk);
        start_bcd = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), 32'd15);
        check("done_at_busy_fall", 32'(done), 32'd1);
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd", 32'(bcd_digits), 32'(e.bcd));
                check("mode", 32'(disp_mode), 32'(e.mode));
                check("ovf", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        reset = 1'b1;
        start_bcd = 1'b0;
        mode_flags = 2'b00;
        day_dist = '0; avg_speed = '0; trip_time = '0; max_speed = '0;
        repeat (3) @(negedge clk);
        check("rst_bcd", 32'(bcd_digits), 32'd0);
        check("rst_mode", 32'(disp_mode), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        // Basic conversion and saturation boundaries
        run_one(2'b00, 1234);
        run_one(2'b11, 9999);
        run_one(2'b11, 12000);
        run_one(2'b11, 0);
        run_one(2'b10, 16383);
        run_one(2'b01, 42);
        run_one(2'b00, 1005);
        run_one(2'b01, 10000);
        wait_empty(50);

        // Requests during SHIFT collapse into one pending conversion
        base = done_cnt;
        @(negedge clk);
        set_metric(2'b01, 57);
        start_bcd = 1'b1;
        sb.push_back(model(57, 2'b01));
        @(negedge clk);
        start_bcd = 1'b0;
        set_metric(2'b10, 360);
        sb.push_back(model(360, 2'b10));
        for (int k = 0; k < 3; k++) begin
            repeat (2) @(negedge clk);
            start_bcd = 1'b1;
            @(negedge clk);
            start_bcd = 1'b0;
        end
        wait_empty(200);
        repeat (40) @(negedge clk);
        check("collapse_count", 32'(done_cnt - base), 32'd2);

        // Inputs wiggling during SHIFT must not disturb the captured value
        @(negedge clk);
        set_metric(2'b01, 777);
        start_bcd = 1'b1;
        sb.push_back(model(777, 2'b01));
        @(negedge clk);
        start_bcd = 1'b0;
        for (int k = 0; k < 14; k++) begin
            mode_flags = 2'($urandom);
            avg_speed  = WIDTH'($urandom);
            day_dist   = WIDTH'($urandom);
            @(negedge clk);
        end
        mode_flags = 2'b00;
        wait_empty(50);

        // Reset in the middle of a conversion discards it
        base = done_cnt;
        @(negedge clk);
        set_metric(2'b00, 4321);
        start_bcd = 1'b1;
        @(negedge clk);
        start_bcd = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_bcd", 32'(bcd_digits), 32'd0);
        check("mid_rst_mode", 32'(disp_mode), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("no_done_after_rst", 32'(done_cnt - base), 32'd0);
        run_one(2'b00, 4321);
        wait_empty(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
